// File: rtl/ft245_pkg.sv
// ---------------------------------------------------------------------------
// ft245_pkg
// Shared definitions for the FT245 responder slice:
//   FT_BUS_W          width of the FT245 parallel data bus
//   rd_state_t        read-strobe FSM encoding
//   wr_state_t        write-strobe FSM encoding
//   ERR_*             bit positions inside err_flags
// ---------------------------------------------------------------------------
package ft245_pkg;

    localparam int FT_BUS_W = 8;
    localparam int ERR_W    = 3;

    localparam int ERR_TX_OVERFLOW  = 0;
    localparam int ERR_RX_UNDERFLOW = 1;
    localparam int ERR_BUS_CONFLICT = 2;

    typedef enum logic [1:0] {
        R_IDLE    = 2'd0,
        R_ACTIVE  = 2'd1,
        R_RECOVER = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_ACTIVE  = 2'd1,
        W_RECOVER = 2'd2
    } wr_state_t;

endpackage

// File: rtl/ft245_responder_if.sv
// ---------------------------------------------------------------------------
// ft245_responder_if
// Handshake bundle between the FT245 responder and its two partners:
//   rxf_n / rd_n / txe_n / wr_n   FT245 strobes and flags (bridge side)
//   host_in_*                     byte stream toward the bridge
//   host_out_*                    byte stream received from the bridge
// slave  : the responder (drives flags, host_in_ready, host_out_*)
// master : the environment (drives strobes, host_in_data/valid, host_out_ready)
// The shared data bus io_245 stays a plain inout port on the responder.
// ---------------------------------------------------------------------------
interface ft245_responder_if;
    import ft245_pkg::*;

    logic                rxf_n;
    logic                rd_n;
    logic                txe_n;
    logic                wr_n;
    logic [FT_BUS_W-1:0] host_in_data;
    logic                host_in_valid;
    logic                host_in_ready;
    logic [FT_BUS_W-1:0] host_out_data;
    logic                host_out_valid;
    logic                host_out_ready;

    modport slave (
        input  rd_n, wr_n, host_in_data, host_in_valid, host_out_ready,
        output rxf_n, txe_n, host_in_ready, host_out_data, host_out_valid
    );

    modport master (
        output rd_n, wr_n, host_in_data, host_in_valid, host_out_ready,
        input  rxf_n, txe_n, host_in_ready, host_out_data, host_out_valid
    );

endinterface

// File: rtl/ft245_responder_byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Synchronous first-word-fall-through byte FIFO.
//   clock_in, reset   clock and synchronous active-high reset
//   push, push_data   write request; accepted when not full, or when full and
//                     a pop happens in the same cycle
//   pop               read request; ignored when empty
//   head              current head byte (valid while !empty)
//   full, empty       status flags
//   level             occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module byte_fifo
    import ft245_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clock_in,
    input  logic                reset,
    input  logic                push,
    input  logic [FT_BUS_W-1:0] push_data,
    input  logic                pop,
    output logic [FT_BUS_W-1:0] head,
    output logic                full,
    output logic                empty,
    output logic [AW:0]         level
);

    logic [FT_BUS_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         level_q, level_d;
    logic                do_push;
    logic                do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push is about to use.
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clock_in) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ft245_responder.sv
// ---------------------------------------------------------------------------
// ft245_responder
// Chip-side emulation of an FT245 parallel FIFO, fully synchronous to clock_in.
//   clock_in, reset   system clock, synchronous active-high reset
//   io_245            shared 8-bit bus, driven by this block only while rd_n=0
//   bus (slave)       rxf_n/txe_n flags, rd_n/wr_n strobes, host_in stream
//                     (toward the bridge), host_out stream (from the bridge)
//   rx_level          occupancy of the host_in -> bridge FIFO
//   tx_level          occupancy of the bridge -> host_out FIFO
//   err_flags         sticky: tx_overflow, rx_underflow, bus_conflict
// ---------------------------------------------------------------------------
module ft245_responder
    import ft245_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clock_in,
    input  logic                 reset,
    inout  wire [FT_BUS_W-1:0]   io_245,
    ft245_responder_if.slave     bus,
    output logic [AW:0]          rx_level,
    output logic [AW:0]          tx_level,
    output logic [ERR_W-1:0]     err_flags
);

    rd_state_t           rd_state_q, rd_state_d;
    wr_state_t           wr_state_q, wr_state_d;
    logic                rd_n_q;
    logic                wr_n_q;
    logic                rd_had_data_q, rd_had_data_d;
    logic                rxf_n_q, rxf_n_d;
    logic                txe_n_q, txe_n_d;
    logic                in_en_q, in_en_d;
    logic [ERR_W-1:0]    err_q, err_d;

    logic                rx_push, rx_pop, rx_full, rx_empty;
    logic [FT_BUS_W-1:0] rx_head;
    logic                tx_push, tx_pop, tx_full, tx_empty;
    logic [FT_BUS_W-1:0] tx_head;
    logic [FT_BUS_W-1:0] rd_byte;

    // host_in_ready is held low through reset and the cycle that releases it.
    assign bus.host_in_ready  = in_en_q && !rx_full;
    assign rx_push            = bus.host_in_valid && bus.host_in_ready;
    assign bus.host_out_valid = !tx_empty;
    assign bus.host_out_data  = tx_head;
    assign tx_pop             = bus.host_out_ready && !tx_empty;
    assign bus.rxf_n          = rxf_n_q;
    assign bus.txe_n          = txe_n_q;
    assign err_flags          = err_q;

    // Reading an empty FIFO presents zeros instead of stale storage.
    assign rd_byte = rx_empty ? '0 : rx_head;
    assign io_245  = bus.rd_n ? {FT_BUS_W{1'bz}} : rd_byte;

    byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clock_in  (clock_in),
        .reset     (reset),
        .push      (rx_push),
        .push_data (bus.host_in_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clock_in  (clock_in),
        .reset     (reset),
        .push      (tx_push),
        .push_data (io_245),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    always_comb begin
        rd_state_d    = rd_state_q;
        wr_state_d    = wr_state_q;
        rd_had_data_d = rd_had_data_q;
        err_d         = err_q;
        rx_pop        = 1'b0;
        tx_push       = 1'b0;
        in_en_d       = 1'b1;

        // Read side: the byte is popped when the strobe is released, and only
        // if there was something to present when the strobe went low.
        case (rd_state_q)
            R_IDLE: begin
                if (!bus.rd_n && rd_n_q) begin
                    rd_state_d    = R_ACTIVE;
                    rd_had_data_d = !rx_empty;
                    if (rx_empty) err_d[ERR_RX_UNDERFLOW] = 1'b1;
                end
            end
            R_ACTIVE: begin
                if (bus.rd_n) begin
                    rd_state_d = R_RECOVER;
                    rx_pop     = rd_had_data_q;
                end
            end
            R_RECOVER: rd_state_d = R_IDLE;
            default:   rd_state_d = R_IDLE;
        endcase

        // Write side: capture on the first cycle wr_n is seen low. A write
        // while our own read drive is on the bus is discarded.
        case (wr_state_q)
            W_IDLE: begin
                if (!bus.wr_n && wr_n_q) begin
                    wr_state_d = W_ACTIVE;
                    if (!bus.rd_n) begin
                        err_d[ERR_BUS_CONFLICT] = 1'b1;
                    end else begin
                        tx_push = 1'b1;
                        if (tx_full && !tx_pop) err_d[ERR_TX_OVERFLOW] = 1'b1;
                    end
                end
            end
            W_ACTIVE: begin
                if (bus.wr_n) wr_state_d = W_RECOVER;
            end
            W_RECOVER: wr_state_d = W_IDLE;
            default:   wr_state_d = W_IDLE;
        endcase

        // rxf_n lags the read FSM by one register, giving two high cycles
        // after each strobe release. txe_n looks at the next write state so
        // it rises on the capture edge itself.
        rxf_n_d = !((rd_state_q == R_IDLE) && !rx_empty);
        txe_n_d = !((wr_state_d == W_IDLE) && !tx_full);
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            rd_state_q    <= R_IDLE;
            wr_state_q    <= W_IDLE;
            rd_n_q        <= 1'b1;
            wr_n_q        <= 1'b1;
            rd_had_data_q <= 1'b0;
            rxf_n_q       <= 1'b1;
            txe_n_q       <= 1'b1;
            in_en_q       <= 1'b0;
            err_q         <= '0;
        end else begin
            rd_state_q    <= rd_state_d;
            wr_state_q    <= wr_state_d;
            rd_n_q        <= bus.rd_n;
            wr_n_q        <= bus.wr_n;
            rd_had_data_q <= rd_had_data_d;
            rxf_n_q       <= rxf_n_d;
            txe_n_q       <= txe_n_d;
            in_en_q       <= in_en_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: tb/tb_ft245_responder.sv
// ---------------------------------------------------------------------------
// tb_ft245_responder
// Bench for ft245_responder: plays the FTDI bridge on rd_n/wr_n/io_245 and
// the host on the two byte streams. Expected bridge-read bytes and expected
// host_out bytes are queued when stimulus is driven and compared when the
// responder produces them.
// ---------------------------------------------------------------------------
module tb_ft245_responder;
    import ft245_pkg::*;

    localparam int DEPTH = 16;

    logic clock_in = 1'b0;
    logic reset    = 1'b1;
    always #5 clock_in = ~clock_in;

    wire  [7:0] io_245;
    logic [7:0] drv_data;
    logic       drv_oe;
    assign io_245 = drv_oe ? drv_data : 8'hzz;

    ft245_responder_if bus_if();
    logic [4:0] rx_level;
    logic [4:0] tx_level;
    logic [2:0] err_flags;

    ft245_responder #(.DEPTH(DEPTH)) dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .io_245    (io_245),
        .bus       (bus_if),
        .rx_level  (rx_level),
        .tx_level  (tx_level),
        .err_flags (err_flags)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] rx_q[$];
    logic [7:0] out_q[$];

    typedef struct {
        logic       rdy;
        logic [7:0] d;
        bit         push_exp;
        logic [4:0] lvl;
        logic       txe;
    } wvec_t;

    wvec_t wtab[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock_in);
        #1;
    endtask

    // Host-side consumer: each accepted host_out byte must be the oldest expected one.
    always @(negedge clock_in) begin
        if (!reset && bus_if.host_out_valid && bus_if.host_out_ready) begin
            if (out_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL host_out_unexpected: actual=%0h required=none", bus_if.host_out_data);
            end else begin
                chk("host_out_data", {24'h0, bus_if.host_out_data}, {24'h0, out_q.pop_front()});
            end
        end
    end

    task automatic host_push(input logic [7:0] d, input bit loop);
        chk("host_in_ready", {31'h0, bus_if.host_in_ready}, 32'h1);
        bus_if.host_in_valid = 1'b1;
        bus_if.host_in_data  = d;
        rx_q.push_back(d);
        if (loop) out_q.push_back(d);
        tick;
        bus_if.host_in_valid = 1'b0;
    endtask

    task automatic bw(input logic [7:0] d, input bit push_exp);
        drv_data    = d;
        drv_oe      = 1'b1;
        bus_if.wr_n = 1'b0;
        if (push_exp) out_q.push_back(d);
        tick;
        chk("txe_n_busy", {31'h0, bus_if.txe_n}, 32'h1);
        tick;
        bus_if.wr_n = 1'b1;
        drv_oe      = 1'b0;
        tick;
        tick;
    endtask

    task automatic br(output logic [7:0] got);
        logic [7:0] exp;
        exp = 8'h00;
        if (rx_q.size() != 0) exp = rx_q.pop_front();
        bus_if.rd_n = 1'b0;
        #1;
        got = io_245;
        chk("rd_data", {24'h0, got}, {24'h0, exp});
        tick;
        bus_if.rd_n = 1'b1;
        tick;
        chk("rxf_n_recover0", {31'h0, bus_if.rxf_n}, 32'h1);
        tick;
        chk("rxf_n_recover1", {31'h0, bus_if.rxf_n}, 32'h1);
    endtask

    task automatic wait_rxf;
        int n;
        n = 0;
        while (bus_if.rxf_n !== 1'b0 && n < 10) begin
            tick;
            n++;
        end
        chk("rxf_n_wait", {31'h0, bus_if.rxf_n}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] got;
        int         n;

        // Write-path vectors: 3 streamed writes, 16 fills, one overflow write.
        wtab[0] = '{1'b1, 8'h11, 1'b1, 5'd0, 1'b0};
        wtab[1] = '{1'b1, 8'h22, 1'b1, 5'd0, 1'b0};
        wtab[2] = '{1'b1, 8'h33, 1'b1, 5'd0, 1'b0};
        for (int i = 0; i < 16; i++) begin
            wtab[3+i].rdy      = 1'b0;
            wtab[3+i].d        = 8'h40 + 8'(i);
            wtab[3+i].push_exp = 1'b1;
            wtab[3+i].lvl      = 5'(i + 1);
            wtab[3+i].txe      = (i == 15);
        end
        wtab[19] = '{1'b0, 8'hFF, 1'b0, 5'd16, 1'b1};

        bus_if.rd_n           = 1'b1;
        bus_if.wr_n           = 1'b1;
        bus_if.host_in_valid  = 1'b0;
        bus_if.host_in_data   = 8'h00;
        bus_if.host_out_ready = 1'b0;
        drv_oe                = 1'b0;
        drv_data              = 8'h00;
        reset                 = 1'b1;
        repeat (3) tick;

        chk("rst_rxf_n", {31'h0, bus_if.rxf_n}, 32'h1);
        chk("rst_txe_n", {31'h0, bus_if.txe_n}, 32'h1);
        chk("rst_host_in_ready", {31'h0, bus_if.host_in_ready}, 32'h0);
        chk("rst_host_out_valid", {31'h0, bus_if.host_out_valid}, 32'h0);
        chk("rst_rx_level", {27'h0, rx_level}, 32'h0);
        chk("rst_tx_level", {27'h0, tx_level}, 32'h0);
        chk("rst_err", {29'h0, err_flags}, 32'h0);

        reset = 1'b0;
        tick;
        chk("post_rst_ready", {31'h0, bus_if.host_in_ready}, 32'h1);
        chk("post_rst_txe_n", {31'h0, bus_if.txe_n}, 32'h0);
        chk("post_rst_rxf_n", {31'h0, bus_if.rxf_n}, 32'h1);

        // Host -> bridge: two bytes, rxf_n low two cycles after the first push.
        host_push(8'hA5, 1'b0);
        chk("rx_level_n1", {27'h0, rx_level}, 32'h1);
        chk("rxf_n_n1", {31'h0, bus_if.rxf_n}, 32'h1);
        host_push(8'h3C, 1'b0);
        chk("rx_level_n2", {27'h0, rx_level}, 32'h2);
        chk("rxf_n_n2", {31'h0, bus_if.rxf_n}, 32'h0);
        br(got);
        chk("rx_level_after_rd1", {27'h0, rx_level}, 32'h1);
        tick;
        chk("rxf_n_next_byte", {31'h0, bus_if.rxf_n}, 32'h0);
        br(got);
        chk("rx_level_after_rd2", {27'h0, rx_level}, 32'h0);
        tick;
        chk("rxf_n_empty", {31'h0, bus_if.rxf_n}, 32'h1);

        // Bridge -> host: table of writes, streaming then filling then overflow.
        for (int i = 0; i < 20; i++) begin
            bus_if.host_out_ready = wtab[i].rdy;
            bw(wtab[i].d, wtab[i].push_exp);
            chk($sformatf("tx_level_v%0d", i), {27'h0, tx_level}, {27'h0, wtab[i].lvl});
            chk($sformatf("txe_n_v%0d", i), {31'h0, bus_if.txe_n}, {31'h0, wtab[i].txe});
        end
        chk("err_overflow", {29'h0, err_flags}, 32'h1);
        chk("out_q_pending", out_q.size(), 32'd16);

        bus_if.host_out_ready = 1'b1;
        n = 0;
        while (tx_level != 5'd0 && n < 40) begin
            tick;
            n++;
        end
        tick;
        chk("drain_tx_level", {27'h0, tx_level}, 32'h0);
        chk("drain_out_q", out_q.size(), 32'd0);
        chk("drain_txe_n", {31'h0, bus_if.txe_n}, 32'h0);

        // Read strobe with nothing queued.
        br(got);
        chk("udf_rx_level", {27'h0, rx_level}, 32'h0);
        chk("udf_err", {29'h0, err_flags}, 32'h3);

        // Write strobe falling while a read is driving the bus.
        host_push(8'h5A, 1'b0);
        tick;
        tick;
        got = 8'h00;
        bus_if.rd_n = 1'b0;
        #1;
        chk("conf_rd_data", {24'h0, io_245}, {24'h0, rx_q.pop_front()});
        tick;
        bus_if.wr_n = 1'b0;
        tick;
        chk("conf_err", {29'h0, err_flags}, 32'h7);
        chk("conf_bus_held", {24'h0, io_245}, 32'h5A);
        bus_if.wr_n = 1'b1;
        bus_if.rd_n = 1'b1;
        tick;
        tick;
        tick;
        chk("conf_tx_level", {27'h0, tx_level}, 32'h0);
        chk("conf_rx_level", {27'h0, rx_level}, 32'h0);
        chk("conf_host_out_valid", {31'h0, bus_if.host_out_valid}, 32'h0);
        chk("conf_txe_n", {31'h0, bus_if.txe_n}, 32'h0);

        // Loopback: bridge reads each byte and writes it straight back.
        for (int i = 0; i < 16; i++) host_push(8'(i), 1'b1);
        chk("loop_rx_full", {27'h0, rx_level}, 32'd16);
        chk("loop_ready_low", {31'h0, bus_if.host_in_ready}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            wait_rxf;
            br(got);
            bw(got, 1'b0);
            chk("loop_txe_n", {31'h0, bus_if.txe_n}, 32'h0);
        end
        n = 0;
        while (out_q.size() != 0 && n < 10) begin
            tick;
            n++;
        end
        chk("loop_out_q", out_q.size(), 32'd0);
        chk("loop_rx_level", {27'h0, rx_level}, 32'h0);

        // Reset in the middle of a stream with a read strobe active.
        host_push(8'h70, 1'b0);
        host_push(8'h71, 1'b0);
        host_push(8'h72, 1'b0);
        bus_if.rd_n = 1'b0;
        reset       = 1'b1;
        tick;
        chk("mid_rst_rx_level", {27'h0, rx_level}, 32'h0);
        chk("mid_rst_tx_level", {27'h0, tx_level}, 32'h0);
        chk("mid_rst_rxf_n", {31'h0, bus_if.rxf_n}, 32'h1);
        chk("mid_rst_txe_n", {31'h0, bus_if.txe_n}, 32'h1);
        chk("mid_rst_err", {29'h0, err_flags}, 32'h0);
        rx_q.delete();
        bus_if.rd_n = 1'b1;
        reset       = 1'b0;
        tick;
        tick;
        chk("after_rst_txe_n", {31'h0, bus_if.txe_n}, 32'h0);
        chk("after_rst_rxf_n", {31'h0, bus_if.rxf_n}, 32'h1);
        chk("after_rst_rx_level", {27'h0, rx_level}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ft245_responder.md
# ft245_responder

Synthesizable emulation of the FT245 chip side of the parallel FIFO interface: it answers the board-side FTDI bridge exactly as the FTDI device would, driving RXF#/TXE# and responding to RD#/WR# on the shared 8-bit bus. Bytes pushed on a host-side stream appear as "PC to board" data. Bytes written by the bridge appear on a host-side output stream. The block is used for FPGA-to-FPGA links over the FT245 pinout and as the in-loop partner for bridge loopback tests. All signals are synchronous to clock_in; no asynchronous FT245 timing is modelled.

## Interface
- DEPTH, 16, entries per direction FIFO; power of two, at least 2.
- AW, $clog2(DEPTH), FIFO address width (derived, do not override).
- clock_in  input  1  system clock
- reset  input  1  synchronous, active-high
- io_245  inout  8  shared data bus; driven only while rd_n low
- rxf_n  output  1  low = byte available for the bridge to read
- rd_n  input  1  bridge read strobe, active low; pop on rising edge
- txe_n  output  1  low = bridge may write a byte
- wr_n  input  1  bridge write strobe, active low; byte captured on falling edge
- host_in_data  input  8  byte to send toward the bridge
- host_in_valid  input  1  host_in_data valid
- host_in_ready  output  1  RX FIFO can accept a byte
- host_out_data  output  8  byte received from the bridge (TX FIFO head)
- host_out_valid  output  1  TX FIFO non-empty
- host_out_ready  input  1  consumer takes host_out_data
- rx_level  output  AW+1  RX FIFO occupancy
- tx_level  output  AW+1  TX FIFO occupancy
- err_flags  output  3  sticky: [0] tx_overflow, [1] rx_underflow, [2] bus_conflict

## Operation
- Two independent byte FIFOs. RX FIFO: host_in → bridge. TX FIFO: bridge → host_out.
- Edge detect: rd_n_q and wr_n_q are the previous-cycle registered copies of rd_n and wr_n. Both reset to 1.
- Read FSM, states R_IDLE, R_ACTIVE, R_RECOVER:
  - R_IDLE → R_ACTIVE when rd_n=0 and rd_n_q=1.
  - R_ACTIVE → R_RECOVER when rd_n=1. On this transition, pop the RX FIFO if it was non-empty at entry.
  - R_RECOVER → R_IDLE unconditionally after 1 cycle.
- io_245 drive is combinational: io_245 = rd_n ? 8'hZZ : rd_byte.
  - rd_byte is the RX FIFO head, or 8'h00 when the FIFO is empty.
- Read while empty: bus drives 8'h00, no pop, err_flags[1] set.
- rxf_n: registered. rxf_n=0 only when state is R_IDLE and the RX FIFO is non-empty; otherwise 1.
- Write FSM, states W_IDLE, W_ACTIVE, W_RECOVER:
  - On wr_n=0 with wr_n_q=1, capture io_245 into the TX FIFO, then go to W_ACTIVE.
  - W_ACTIVE waits for wr_n=1, then goes to W_RECOVER.
  - W_RECOVER lasts 1 cycle, then returns to W_IDLE.
- Write while TX FIFO full: byte dropped, err_flags[0] set.
- txe_n: registered. txe_n=0 only when state is W_IDLE and the TX FIFO is not full.
- wr_n falling while rd_n=0: write ignored, err_flags[2] set. The read is unaffected.
- host_in_ready = !rx_full.
- host_out_valid = !tx_empty, with host_out_data = TX FIFO head (first-word-fall-through).
- Same-cycle push and pop on one FIFO: both take effect and the level is unchanged.
  - A push is accepted when the FIFO is full if a pop occurs in the same cycle.
- err_flags clear only on reset.

## Timing
- Reset values:
  - rxf_n=1, txe_n=1, io_245 high-Z (unless rd_n=0).
  - host_in_ready=1 one cycle after reset deasserts, 0 while reset is high.
  - host_out_valid=0, levels 0, err_flags 0, both FSMs idle.
- host_in push accepted at edge N → rx_level updates at N+1; rxf_n=0 at N+2.
- Bus data is valid in the same cycle rd_n goes low (combinational).
- Pop at the edge where rd_n=1 is sampled in R_ACTIVE.
- rxf_n is high for at least 2 cycles after each read (R_RECOVER plus the registered update). The next byte is signalled at the earliest 2 cycles after rd_n rises.
- Write captured at the edge where wr_n=0 is first sampled → host_out_valid=1 at the next cycle.
- txe_n stays high from the capture edge until 1 cycle after W_RECOVER.
- Reset mid-transfer: FIFO contents are discarded, FSMs return to idle, and the bus is released as soon as rd_n rises.

## Structure
- ft245_pkg holds:
  - the FT245 bus width constant (8)
  - the read and write FSM state encodings
  - the err_flags bit indices
- One sub-module, byte_fifo (parameter DEPTH): synchronous, first-word-fall-through, with full/empty/level outputs, instantiated twice.
- The strobe edge detect and both FSMs live in ft245_responder.

## Test plan
- Push 8'hA5, 8'h3C on host_in → rxf_n low at N+2. Two bridge reads return A5 then 3C, each showing ≥2 cycles of rxf_n high between them. rx_level ends at 0.
- Bridge writes 8'h11, 8'h22, 8'h33 with host_out_ready=1 → host_out yields 11, 22, 33 in order. txe_n pulses high after each write.
- Fill TX FIFO (16 writes, host_out_ready=0) → txe_n=1. A 17th forced write of 8'hFF is dropped, err_flags[0]=1, and tx_level stays 16.
- RD# strobe with RX FIFO empty → io_245 reads 8'h00, rx_level stays 0, err_flags[1]=1.
- wr_n falls during rd_n low → no TX push, err_flags[2]=1, and the read still pops correctly.
- Loop back through the FTDI bridge: host_in 0x00..0x0F → the bridge's top-side output matches the sequence. Assert reset mid-stream → levels 0, rxf_n=1, txe_n=1 next cycle.
